// File: rtl/regbank_reader.sv
// regbank_reader
//   Read side of the 16x16-bit register bank. It turns operand-fetch requests
//   into registered A/B operand pairs over a valid/ready handshake. It also
//   runs a dump engine that streams all 16 registers out one word at a time.
//
//   Optional feature macro: REGREAD_BYPASS_EN
//     defined     : a bank write landing in the sampling cycle (regEnable[i])
//                   is forwarded from ALUBus.
//     not defined : the live bank outputs are always used. A same-cycle write
//                   returns the pre-write value. regEnable/ALUBus are unused.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     r0..r15               live register-bank outputs
//     regEnable, ALUBus     bank write enables / write data (forwarding)
//     rd_req, rd_addr_a/b   operand-fetch request and source indices
//     rd_ready              request accepted when high together with rd_req
//     opA, opB, rd_valid    registered operands and their valid flag
//     rd_accept             consumer takes opA/opB
//     dump_start            single-cycle dump request
//     dump_busy             dump engine active
//     dump_valid/index/data presented dump word
//     dump_ready            dump consumer accepts the current word
//     dump_done             one-cycle pulse after word 15 is accepted
module regbank_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [15:0] r8,
    input  logic [15:0] r9,
    input  logic [15:0] r10,
    input  logic [15:0] r11,
    input  logic [15:0] r12,
    input  logic [15:0] r13,
    input  logic [15:0] r14,
    input  logic [15:0] r15,
    input  logic [15:0] regEnable,
    input  logic [15:0] ALUBus,
    input  logic        rd_req,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic        rd_ready,
    output logic [15:0] opA,
    output logic [15:0] opB,
    output logic        rd_valid,
    input  logic        rd_accept,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    output logic [3:0]  dump_index,
    output logic [15:0] dump_data,
    input  logic        dump_ready,
    output logic        dump_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    state_t             state;
    logic [15:0][15:0]  rf;
    logic               dump_go;
    logic               rd_take;

    assign rf = {r15, r14, r13, r12, r11, r10, r9, r8,
                 r7,  r6,  r5,  r4,  r3,  r2,  r1, r0};

`ifdef REGREAD_BYPASS_EN
    function automatic logic [15:0] fwd(input logic [3:0] i);
        return regEnable[i] ? ALUBus : rf[i];
    endfunction
`else
    function automatic logic [15:0] fwd(input logic [3:0] i);
        return rf[i];
    endfunction

    // Write-port inputs only matter when forwarding is built in.
    logic unused_wr_port;
    assign unused_wr_port = ^{regEnable, ALUBus};
`endif

    assign rd_ready  = (!rd_valid || rd_accept) && (state == IDLE);
    assign dump_busy = (state != IDLE);

    // A dump may only start once the operand slot is free (or being freed),
    // and it shadows any fetch request presented in the same cycle.
    assign dump_go = dump_start && rd_ready;
    assign rd_take = rd_req && rd_ready && !dump_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            opA        <= '0;
            opB        <= '0;
            rd_valid   <= 1'b0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            if (rd_take) begin
                opA      <= fwd(rd_addr_a);
                opB      <= fwd(rd_addr_b);
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_accept) begin
                rd_valid <= 1'b0;
            end

            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_go) state <= LOAD;
                end
                LOAD: begin
                    // Sampled once; later writes while stalled in SHOW are not seen.
                    dump_data  <= fwd(dump_index);
                    dump_valid <= 1'b1;
                    state      <= SHOW;
                end
                SHOW: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_index == 4'd15) begin
                            dump_index <= '0;
                            dump_done  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            dump_index <= dump_index + 4'd1;
                            state      <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_reader.sv
module tb_regbank_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] r [16];
    logic [15:0] regEnable, ALUBus;
    logic        rd_req;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic        rd_ready;
    logic [15:0] opA, opB;
    logic        rd_valid, rd_accept;
    logic        dump_start, dump_busy, dump_valid;
    logic [3:0]  dump_index;
    logic [15:0] dump_data;
    logic        dump_ready, dump_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regbank_reader dut (
        .clk(clk), .reset(reset),
        .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),
        .r4(r[4]),   .r5(r[5]),   .r6(r[6]),   .r7(r[7]),
        .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
        .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
        .regEnable(regEnable), .ALUBus(ALUBus),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_ready(rd_ready), .opA(opA), .opB(opB),
        .rd_valid(rd_valid), .rd_accept(rd_accept),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_index(dump_index),
        .dump_data(dump_data), .dump_ready(dump_ready),
        .dump_done(dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] exp5;
    int          widx, busy_n, first_v, done_e;
    logic        got_done, rdv_seen;

    initial begin
        reset = 1'b1; regEnable = '0; ALUBus = '0;
        rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0; rd_accept = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 16; i++) r[i] = '0;

        // ---- reset state
        tick(); tick();
        chk("rst_opA", opA, 0);
        chk("rst_opB", opB, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_index", dump_index, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_dump_busy", dump_busy, 0);
        reset = 1'b0;
        #1 chk("rst_rd_ready", rd_ready, 1);

        // ---- basic fetch, consumed immediately
        r[3] = 16'h1234; r[9] = 16'hBEEF;
        rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd9; rd_accept = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("fetch_opA", opA, 16'h1234);
        chk("fetch_opB", opB, 16'hBEEF);
        chk("fetch_valid", rd_valid, 1);
        tick();
        chk("fetch_valid_clr", rd_valid, 0);
        chk("fetch_opA_hold", opA, 16'h1234);

        // ---- same-cycle write to the fetched register, a == b
        r[5] = 16'h0011; regEnable = 16'h0020; ALUBus = 16'h00AA;
        rd_req = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        tick();
        rd_req = 1'b0; regEnable = '0; ALUBus = '0;
`ifdef REGREAD_BYPASS_EN
        exp5 = 16'h00AA;
`else
        exp5 = 16'h0011;
`endif
        chk("fwd_opA", opA, exp5);
        chk("fwd_opB", opB, exp5);

        // ---- stall: operands frozen, new request held off
        rd_accept = 1'b0;
        r[1] = 16'h7777; r[2] = 16'h2222; r[5] = 16'h5555;
        rd_req = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall_ready", rd_ready, 0);
            tick();
            chk("stall_opA", opA, exp5);
            chk("stall_valid", rd_valid, 1);
        end
        // dump_start is dropped while the slot is occupied and not consumed
        dump_start = 1'b1; rd_req = 1'b0;
        tick();
        dump_start = 1'b0;
        chk("dump_ignored_busy", dump_busy, 0);
        tick();
        chk("dump_not_queued", dump_busy, 0);
        rd_req = 1'b1; rd_accept = 1'b1;
        #1 chk("unstall_ready", rd_ready, 1);
        tick();
        chk("unstall_opA", opA, 16'h7777);
        chk("unstall_opB", opB, 16'h2222);
        chk("unstall_valid", rd_valid, 1);

        // ---- back-to-back, one result per cycle
        for (int i = 0; i < 16; i++) r[i] = 16'hA000 + 16'(i * 7);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
            tick();
            chk("b2b_opA", opA, 16'hA000 + 16'(i * 7));
            chk("b2b_opB", opB, 16'hA000 + 16'((15 - i) * 7));
            chk("b2b_valid", rd_valid, 1);
        end
        rd_req = 1'b0;
        tick();
        chk("b2b_drain", rd_valid, 0);

        // ---- full dump with a competing fetch request held high
        for (int i = 0; i < 16; i++) r[i] = 16'h0100 + 16'(i);
        dump_ready = 1'b1; dump_start = 1'b1; rd_req = 1'b1; rd_addr_a = 4'd4;
        widx = 0; busy_n = 0; first_v = 0; done_e = 0;
        got_done = 1'b0; rdv_seen = 1'b0;
        for (int e = 1; e <= 60 && !got_done; e++) begin
            tick();
            dump_start = 1'b0;
            if (dump_busy) busy_n++;
            if (rd_valid) rdv_seen = 1'b1;
            if (dump_valid && first_v == 0) first_v = e;
            if (dump_valid) begin
                chk("dump_index", dump_index, widx);
                chk("dump_data", dump_data, 16'h0100 + 16'(widx));
                widx++;
            end
            if (dump_done) begin
                got_done = 1'b1; done_e = e; rd_req = 1'b0;
                chk("dump_done_idx", dump_index, 0);
                chk("dump_done_valid", dump_valid, 0);
                chk("dump_done_busy", dump_busy, 0);
            end
        end
        chk("dump_got_done", got_done, 1);
        chk("dump_words", widx, 16);
        chk("dump_first_valid_edge", first_v, 2);
        chk("dump_done_edge", done_e, 33);
        chk("dump_busy_cycles", busy_n, 32);
        chk("dump_blocked_rd", rdv_seen, 0);
        rd_req = 1'b0;
        tick();
        chk("dump_done_pulse", dump_done, 0);
        chk("dump_after_rdv", rd_valid, 0);

        // ---- reset in SHOW with index 7
        dump_start = 1'b1;
        got_done = 1'b0;
        for (int e = 0; e < 40 && !got_done; e++) begin
            tick();
            dump_start = 1'b0;
            if (dump_valid && dump_index == 4'd7) got_done = 1'b1;
        end
        chk("abort_reached_7", got_done, 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", dump_busy, 0);
        chk("abort_valid", dump_valid, 0);
        chk("abort_index", dump_index, 0);
        chk("abort_data", dump_data, 0);
        chk("abort_done", dump_done, 0);
        reset = 1'b0;
        tick();
        chk("abort_no_done", dump_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_reader.md
# regbank_reader

Read-side companion to the 16×16-bit register bank. It turns operand-fetch requests into registered A/B operand pairs over a valid/ready handshake, forwarding any write landing in the same cycle. It also provides a sequential dump engine that streams all 16 registers out one at a time for debug and readback. It sits between the register bank outputs and the ALU/controller.

## Interface
- No parameters. Data width is fixed at 16 bits and register count at 16.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `r0`…`r15`  input  16 each  live register-bank outputs.
- `regEnable`  input  16  bank write enables, one bit per register; used for forwarding.
- `ALUBus`  input  16  bank write data; used for forwarding.
- `rd_req`  input  1  operand-fetch request valid.
- `rd_addr_a`, `rd_addr_b`  input  4 each  source register indices.
- `rd_ready`  output  1  request accepted this cycle when high with `rd_req`.
- `opA`, `opB`  output  16 each  fetched operands.
- `rd_valid`  output  1  `opA`/`opB` hold an unconsumed result.
- `rd_accept`  input  1  consumer takes the result when high with `rd_valid`.
- `dump_start`  input  1  single-cycle request to begin a dump.
- `dump_busy`  output  1  dump engine is active.
- `dump_valid`  output  1  `dump_index`/`dump_data` are presented.
- `dump_index`  output  4  register index being presented.
- `dump_data`  output  16  value of that register.
- `dump_ready`  input  1  dump consumer accepts the current word.
- `dump_done`  output  1  one-cycle pulse after word 15 is accepted.

## Operation
- `rd_ready` = (!`rd_valid` || `rd_accept`) && state == IDLE.
- A request is accepted when `rd_req` && `rd_ready`. On the next edge:
  - `opA` ← fwd(`rd_addr_a`), `opB` ← fwd(`rd_addr_b`).
  - `rd_valid` ← 1.
- fwd(i) = `ALUBus` if `regEnable[i]` is high in the accept cycle, otherwise `r<i>`.
- `rd_addr_a` == `rd_addr_b` is legal; both operands get the same value.
- When `rd_valid` && `rd_accept` and there is no new accept, `rd_valid` ← 0 next edge. `opA`/`opB` retain their last value.
- Accept and consume in the same cycle: `rd_valid` stays 1 and the new operands load. This gives full throughput of one request per cycle.
- While `rd_valid` && !`rd_accept`, `opA`/`opB` are frozen. They do not track later writes.
- Dump FSM states:
  - IDLE → LOAD on `dump_start`, only when !`rd_valid` or `rd_accept` is high that cycle. Otherwise the start is ignored, not queued. `dump_start` also takes priority over `rd_req` that cycle; the request is not accepted.
  - LOAD (1 cycle): `dump_data` ← fwd(`dump_index`), `dump_valid` ← 1 → SHOW.
  - SHOW: hold the outputs until `dump_ready`. On handshake:
    - If index < 15: `dump_index` += 1, `dump_valid` ← 0 → LOAD.
    - If index == 15: `dump_valid` ← 0, `dump_index` ← 0, `dump_done` pulse → IDLE.
- `dump_busy` = state != IDLE.
- `dump_start` is ignored outside IDLE.
- `dump_data` is sampled once in LOAD. A write to that register while stalled in SHOW is not reflected.

## Timing
- Request-to-`rd_valid` latency is 1 cycle.
- A dump takes 32 cycles minimum: 2 per word with `dump_ready` held high. `dump_valid` first rises 2 edges after `dump_start`.
- Reset values: `opA`=`opB`=0, `rd_valid`=0, state=IDLE, `dump_valid`=0, `dump_index`=0, `dump_data`=0, `dump_done`=0.
- `rd_ready` reads 1 and `dump_busy` reads 0 out of reset.
- Reset mid-dump or with `rd_valid` high aborts immediately. All outputs go to their reset values on the next edge, and there is no `dump_done` pulse.
- `reset` and `rd_req`/`dump_start` in the same cycle: reset wins.

## Configuration
- `REGREAD_BYPASS_EN` defined: fwd(i) uses `ALUBus` when `regEnable[i]` is high, as above.
- Not defined: fwd(i) = `r<i>` always. A same-cycle write returns the pre-write value, and the new value is visible only to a request accepted on a later cycle. `regEnable`/`ALUBus` are unused.

## Test plan
- Preload r3=0x1234, r9=0xBEEF. Request a=3, b=9 with `rd_accept`=1 → next cycle `opA`=0x1234, `opB`=0xBEEF, `rd_valid`=1, then `rd_valid`=0.
- Request a=5 with `regEnable`=0x0020, `ALUBus`=0x00AA, old r5=0x0011 → `opA`=0x00AA with the macro defined, 0x0011 without it.
- Hold `rd_accept`=0 after a result → `rd_ready`=0, `opA` stable for 5 cycles. A further `rd_req` is not accepted until `rd_accept` goes high.
- Back-to-back requests with `rd_accept`=1 for addresses 0..15 → one result per cycle, values match rN.
- Set rN=0x100+N and pulse `dump_start` with `dump_ready`=1 → 16 words with index 0..15 and data 0x100..0x10F, `dump_done` after word 15, 32 cycles total. Also check that a `rd_req` during the dump is not accepted.
- Assert `reset` while in SHOW with index 7 → next cycle `dump_busy`=0, `dump_valid`=0, `dump_index`=0, no `dump_done`.
